alu_sequencer: RTL and testbench

- Front-end controller for the single-cycle registered ALU (adder, logic, compare ops).
- Accepts one operation at a time over a valid/ready request channel and drives the ALU's opcode, operand and enable inputs.
- Captures the ALU's registered result and returns it on a valid/ready response channel.
- Adds a multi-cycle `MUL` operation: shift-and-add that reuses the ALU's `ADD` path. No separate multiplier exists.

---
 rtl/alu_sequencer_pkg.sv | 21 ++
 rtl/alu_sequencer.sv | 163 ++++++++++++++++
 tb/tb_alu_sequencer.sv | 246 ++++++++++++++++++++++++
 3 files changed

// File: rtl/alu_sequencer_pkg.sv
// alu_sequencer_pkg: shared definitions for the ALU front-end sequencer.
//   - default operand and opcode widths (must match the ALU)
//   - opcode values understood by the ALU, plus OP_MUL, which is handled
//     entirely by the sequencer and never reaches the ALU
package alu_sequencer_pkg;

    localparam int DEF_WORD_SIZE   = 16;
    localparam int DEF_OPCODE_SIZE = 4;

    localparam logic [DEF_OPCODE_SIZE-1:0] OP_ADD = 4'h0;
    localparam logic [DEF_OPCODE_SIZE-1:0] OP_SUB = 4'h1;
    localparam logic [DEF_OPCODE_SIZE-1:0] OP_AND = 4'h2;
    localparam logic [DEF_OPCODE_SIZE-1:0] OP_OR  = 4'h3;
    localparam logic [DEF_OPCODE_SIZE-1:0] OP_XOR = 4'h4;
    localparam logic [DEF_OPCODE_SIZE-1:0] OP_NOT = 4'h5;
    localparam logic [DEF_OPCODE_SIZE-1:0] OP_SLT = 4'h6;
    localparam logic [DEF_OPCODE_SIZE-1:0] OP_EQ  = 4'h7;
    // The ALU leaves this value unused; the sequencer decodes it itself.
    localparam logic [DEF_OPCODE_SIZE-1:0] OP_MUL = 4'hF;

endpackage

// File: rtl/alu_sequencer.sv
// alu_sequencer: front-end controller for a single-cycle registered ALU.
// Accepts one operation at a time, drives the ALU, captures its registered
// result and returns it on a response channel. MUL is done here as a
// shift-and-add loop that reuses the ALU ADD path.
//
// Ports:
//   clock, reset_n                  clock, async active-low reset
//   req_valid/req_ready             request handshake (ready only in IDLE)
//   req_opcode, req_a, req_b        request opcode and operands
//   resp_valid/resp_ready           response handshake
//   resp_data                       result, stable while resp_valid
//   busy                            high whenever not IDLE
//   alu_enable, alu_opcode,
//   alu_in1, alu_in2                drive the ALU (hold when not enabled)
//   alu_result                      ALU registered output
module alu_sequencer
    import alu_sequencer_pkg::*;
#(
    parameter int WORD_SIZE   = DEF_WORD_SIZE,
    parameter int OPCODE_SIZE = DEF_OPCODE_SIZE,
    parameter int CNT_W       = $clog2(WORD_SIZE + 1)
) (
    input  logic                   clock,
    input  logic                   reset_n,
    input  logic                   req_valid,
    output logic                   req_ready,
    input  logic [OPCODE_SIZE-1:0] req_opcode,
    input  logic [WORD_SIZE-1:0]   req_a,
    input  logic [WORD_SIZE-1:0]   req_b,
    output logic                   resp_valid,
    input  logic                   resp_ready,
    output logic [WORD_SIZE-1:0]   resp_data,
    output logic                   busy,
    output logic                   alu_enable,
    output logic [OPCODE_SIZE-1:0] alu_opcode,
    output logic [WORD_SIZE-1:0]   alu_in1,
    output logic [WORD_SIZE-1:0]   alu_in2,
    input  logic [WORD_SIZE-1:0]   alu_result
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ISSUE,
        S_CAPT,
        S_M_STEP,
        S_M_ISSUE,
        S_M_CAPT,
        S_RESP
    } state_t;

    state_t                 state_q, state_d;
    logic [WORD_SIZE-1:0]   acc_q, acc_d;
    logic [WORD_SIZE-1:0]   mcand_q, mcand_d;
    logic [WORD_SIZE-1:0]   mplier_q, mplier_d;
    logic [CNT_W-1:0]       count_q, count_d;
    logic [WORD_SIZE-1:0]   resp_data_q, resp_data_d;
    logic [OPCODE_SIZE-1:0] alu_opcode_q, alu_opcode_d;
    logic [WORD_SIZE-1:0]   alu_in1_q, alu_in1_d;
    logic [WORD_SIZE-1:0]   alu_in2_q, alu_in2_d;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= S_IDLE;
            acc_q        <= '0;
            mcand_q      <= '0;
            mplier_q     <= '0;
            count_q      <= '0;
            resp_data_q  <= '0;
            alu_opcode_q <= '0;
            alu_in1_q    <= '0;
            alu_in2_q    <= '0;
        end else begin
            state_q      <= state_d;
            acc_q        <= acc_d;
            mcand_q      <= mcand_d;
            mplier_q     <= mplier_d;
            count_q      <= count_d;
            resp_data_q  <= resp_data_d;
            alu_opcode_q <= alu_opcode_d;
            alu_in1_q    <= alu_in1_d;
            alu_in2_q    <= alu_in2_d;
        end
    end

    // The ALU drive registers are loaded on the transition into ISSUE /
    // M_ISSUE, so they are already valid in the cycle alu_enable is high
    // and simply hold their last value afterwards.
    always_comb begin
        state_d      = state_q;
        acc_d        = acc_q;
        mcand_d      = mcand_q;
        mplier_d     = mplier_q;
        count_d      = count_q;
        resp_data_d  = resp_data_q;
        alu_opcode_d = alu_opcode_q;
        alu_in1_d    = alu_in1_q;
        alu_in2_d    = alu_in2_q;

        case (state_q)
            S_IDLE: begin
                if (req_valid) begin
                    if (req_opcode == OPCODE_SIZE'(OP_MUL)) begin
                        acc_d    = '0;
                        mcand_d  = req_a;
                        mplier_d = req_b;
                        count_d  = '0;
                        state_d  = S_M_STEP;
                    end else begin
                        alu_opcode_d = req_opcode;
                        alu_in1_d    = req_a;
                        alu_in2_d    = req_b;
                        state_d      = S_ISSUE;
                    end
                end
            end
            S_ISSUE: state_d = S_CAPT;
            S_CAPT: begin
                resp_data_d = alu_result;
                state_d     = S_RESP;
            end
            S_M_STEP: begin
                // Early exit once no set multiplier bits remain.
                if (mplier_q == '0 || count_q == CNT_W'(WORD_SIZE)) begin
                    resp_data_d = acc_q;
                    state_d     = S_RESP;
                end else if (mplier_q[0]) begin
                    alu_opcode_d = OPCODE_SIZE'(OP_ADD);
                    alu_in1_d    = acc_q;
                    alu_in2_d    = mcand_q;
                    state_d      = S_M_ISSUE;
                end else begin
                    mcand_d  = mcand_q << 1;
                    mplier_d = mplier_q >> 1;
                    count_d  = count_q + CNT_W'(1);
                end
            end
            S_M_ISSUE: state_d = S_M_CAPT;
            S_M_CAPT: begin
                acc_d    = alu_result;
                mcand_d  = mcand_q << 1;
                mplier_d = mplier_q >> 1;
                count_d  = count_q + CNT_W'(1);
                state_d  = S_M_STEP;
            end
            S_RESP: begin
                if (resp_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign req_ready  = (state_q == S_IDLE);
    assign busy       = (state_q != S_IDLE);
    assign resp_valid = (state_q == S_RESP);
    assign resp_data  = resp_data_q;
    assign alu_enable = (state_q == S_ISSUE) || (state_q == S_M_ISSUE);
    assign alu_opcode = alu_opcode_q;
    assign alu_in1    = alu_in1_q;
    assign alu_in2    = alu_in2_q;

endmodule

// File: tb/tb_alu_sequencer.sv
// tb_alu_sequencer: directed bench for alu_sequencer paired with a small
// behavioural model of the registered ALU.
module tb_alu_sequencer;
    import alu_sequencer_pkg::*;

    localparam int W  = 16;
    localparam int OW = 4;

    logic          clock;
    logic          reset_n;
    logic          req_valid;
    logic          req_ready;
    logic [OW-1:0] req_opcode;
    logic [W-1:0]  req_a;
    logic [W-1:0]  req_b;
    logic          resp_valid;
    logic          resp_ready;
    logic [W-1:0]  resp_data;
    logic          busy;
    logic          alu_enable;
    logic [OW-1:0] alu_opcode;
    logic [W-1:0]  alu_in1;
    logic [W-1:0]  alu_in2;
    logic [W-1:0]  alu_result;

    int checks = 0;
    int errors = 0;
    int en_cycles[$];

    alu_sequencer #(.WORD_SIZE(W), .OPCODE_SIZE(OW)) dut (
        .clock      (clock),
        .reset_n    (reset_n),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_opcode (req_opcode),
        .req_a      (req_a),
        .req_b      (req_b),
        .resp_valid (resp_valid),
        .resp_ready (resp_ready),
        .resp_data  (resp_data),
        .busy       (busy),
        .alu_enable (alu_enable),
        .alu_opcode (alu_opcode),
        .alu_in1    (alu_in1),
        .alu_in2    (alu_in2),
        .alu_result (alu_result)
    );

    // Registered ALU model; unknown opcodes return 0.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            alu_result <= '0;
        end else if (alu_enable) begin
            case (alu_opcode)
                OP_ADD:  alu_result <= alu_in1 + alu_in2;
                OP_SUB:  alu_result <= alu_in1 - alu_in2;
                OP_AND:  alu_result <= alu_in1 & alu_in2;
                OP_OR:   alu_result <= alu_in1 | alu_in2;
                OP_XOR:  alu_result <= alu_in1 ^ alu_in2;
                OP_NOT:  alu_result <= ~alu_in1;
                OP_SLT:  alu_result <= {{(W-1){1'b0}}, (alu_in1 < alu_in2)};
                OP_EQ:   alu_result <= {{(W-1){1'b0}}, (alu_in1 == alu_in2)};
                default: alu_result <= '0;
            endcase
        end
    end

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic tick;
        @(negedge clock);
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Issues one request in the current (IDLE) cycle = cycle 0, waits for
    // resp_valid with a bound, records enable cycles, and completes the
    // response handshake (resp_ready is expected to be 1).
    task automatic run_op(input logic [OW-1:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                          output int lat, output logic [W-1:0] data);
        en_cycles.delete();
        lat  = -1;
        data = '0;
        req_valid  = 1'b1;
        req_opcode = op;
        req_a      = a;
        req_b      = b;
        tick();
        req_valid = 1'b0;
        for (int c = 1; c <= 200; c++) begin
            if (alu_enable) en_cycles.push_back(c);
            if (resp_valid) begin
                lat  = c;
                data = resp_data;
                break;
            end
            tick();
        end
        tick();
    endtask

    int           lat;
    logic [W-1:0] data;
    int           en_seen;

    initial begin
        reset_n    = 1'b0;
        req_valid  = 1'b0;
        req_opcode = '0;
        req_a      = '0;
        req_b      = '0;
        resp_ready = 1'b1;
        tick();
        tick();

        check("rst_resp_valid", 32'(resp_valid), 32'd0);
        check("rst_resp_data",  32'(resp_data),  32'd0);
        check("rst_alu_enable", 32'(alu_enable), 32'd0);
        check("rst_alu_opcode", 32'(alu_opcode), 32'd0);
        check("rst_alu_in1",    32'(alu_in1),    32'd0);
        check("rst_alu_in2",    32'(alu_in2),    32'd0);
        check("rst_busy",       32'(busy),       32'd0);
        reset_n = 1'b1;
        tick();
        check("idle_req_ready", 32'(req_ready), 32'd1);

        // ADD 7 + 9, stepped cycle by cycle.
        req_valid = 1'b1; req_opcode = OP_ADD; req_a = 16'h0007; req_b = 16'h0009;
        tick();
        req_valid = 1'b0;
        check("add_c1_enable", 32'(alu_enable), 32'd1);
        check("add_c1_opcode", 32'(alu_opcode), 32'(OP_ADD));
        check("add_c1_in1",    32'(alu_in1),    32'h7);
        check("add_c1_in2",    32'(alu_in2),    32'h9);
        check("add_c1_busy",   32'(busy),       32'd1);
        check("add_c1_ready",  32'(req_ready),  32'd0);
        tick();
        check("add_c2_enable", 32'(alu_enable), 32'd0);
        check("add_c2_valid",  32'(resp_valid), 32'd0);
        tick();
        check("add_c3_valid",  32'(resp_valid), 32'd1);
        check("add_c3_data",   32'(resp_data),  32'h0010);
        tick();
        check("add_c4_ready",  32'(req_ready),  32'd1);
        check("add_c4_busy",   32'(busy),       32'd0);
        check("add_c4_valid",  32'(resp_valid), 32'd0);

        // MUL 3 * 5: ADDs at cycles 2 and 6, response at cycle 9.
        run_op(OP_MUL, 16'd3, 16'd5, lat, data);
        check("mul35_lat",   32'(lat), 32'd9);
        check("mul35_data",  32'(data), 32'h000F);
        check("mul35_nadd",  32'(en_cycles.size()), 32'd2);
        check("mul35_add0",  32'(en_cycles[0]), 32'd2);
        check("mul35_add1",  32'(en_cycles[1]), 32'd6);
        check("mul35_idle",  32'(req_ready), 32'd1);

        // MUL by zero: immediate exit, no ALU activity.
        run_op(OP_MUL, 16'h1234, 16'h0000, lat, data);
        check("mul0_lat",  32'(lat), 32'd2);
        check("mul0_data", 32'(data), 32'h0000);
        check("mul0_nadd", 32'(en_cycles.size()), 32'd0);

        // MUL 0xFFFF * 0xFFFF: 16 ADDs, low word of 0xFFFE0001.
        run_op(OP_MUL, 16'hFFFF, 16'hFFFF, lat, data);
        check("mulff_lat",  32'(lat), 32'd50);
        check("mulff_data", 32'(data), 32'h0001);
        check("mulff_nadd", 32'(en_cycles.size()), 32'd16);

        // Unknown opcode is forwarded and yields 0.
        run_op(4'hE, 16'h5555, 16'h0005, lat, data);
        check("unk_lat",    32'(lat), 32'd3);
        check("unk_data",   32'(data), 32'h0000);
        check("unk_opcode", 32'(alu_opcode), 32'hE);
        check("unk_in1",    32'(alu_in1), 32'h5555);

        // XOR with back-pressure; a competing request must wait.
        resp_ready = 1'b0;
        req_valid = 1'b1; req_opcode = OP_XOR; req_a = 16'hF0F0; req_b = 16'h0FF0;
        tick();
        req_valid = 1'b1; req_opcode = OP_ADD; req_a = 16'h0001; req_b = 16'h0001;
        tick();
        tick();
        check("xor_c3_valid", 32'(resp_valid), 32'd1);
        check("xor_c3_data",  32'(resp_data),  32'hFF00);
        en_seen = 0;
        for (int i = 0; i < 5; i++) begin
            tick();
            if (alu_enable) en_seen++;
            check("xor_hold_valid", 32'(resp_valid), 32'd1);
            check("xor_hold_data",  32'(resp_data),  32'hFF00);
            check("xor_hold_ready", 32'(req_ready),  32'd0);
        end
        check("xor_no_issue", 32'(en_seen), 32'd0);
        resp_ready = 1'b1;
        tick();
        check("xor_after_ready", 32'(req_ready), 32'd1);
        tick();
        req_valid = 1'b0;
        check("next_enable", 32'(alu_enable), 32'd1);
        check("next_in1",    32'(alu_in1),    32'h0001);
        tick();
        tick();
        check("next_valid", 32'(resp_valid), 32'd1);
        check("next_data",  32'(resp_data),  32'h0002);
        tick();

        // Reset in M_CAPT of MUL 7 * 9.
        req_valid = 1'b1; req_opcode = OP_MUL; req_a = 16'd7; req_b = 16'd9;
        tick();
        req_valid = 1'b0;
        tick();
        check("mr_c2_enable", 32'(alu_enable), 32'd1);
        check("mr_c2_in2",    32'(alu_in2),    32'd7);
        tick();
        check("mr_c3_busy",   32'(busy),       32'd1);
        reset_n = 1'b0;
        #1;
        check("mr_rst_busy",   32'(busy),       32'd0);
        check("mr_rst_valid",  32'(resp_valid), 32'd0);
        check("mr_rst_enable", 32'(alu_enable), 32'd0);
        check("mr_rst_in2",    32'(alu_in2),    32'd0);
        check("mr_rst_data",   32'(resp_data),  32'd0);
        tick();
        reset_n = 1'b1;
        en_seen = 0;
        for (int i = 0; i < 4; i++) begin
            tick();
            if (resp_valid || alu_enable) en_seen++;
        end
        check("mr_no_stale", 32'(en_seen), 32'd0);
        run_op(OP_SUB, 16'd10, 16'd3, lat, data);
        check("sub_lat",  32'(lat), 32'd3);
        check("sub_data", 32'(data), 32'h0007);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
